// File: rtl/quad_decoder_if.sv
// Encoder-side bundle for one quad_decoder channel: raw phases and clear in, level and diagnostics out.
// The slave modport is the decoder; the master modport is whoever drives the pins and reads the level.
interface quad_decoder_if #(
    parameter int WIDTH = 8
);
    logic             enc_a;
    logic             enc_b;
    logic             clear;
    logic [WIDTH-1:0] value;
    logic             step;
    logic             dir;
    logic             err;
    logic [7:0]       err_count;

    modport master (
        output enc_a, enc_b, clear,
        input  value, step, dir, err, err_count
    );

    modport slave (
        input  enc_a, enc_b, clear,
        output value, step, dir, err, err_count
    );
endinterface

// File: rtl/quad_decoder.sv
// Rotary-encoder front end: synchronise and de-glitch A/B, decode 4x quadrature, divide to detents
// and keep a WIDTH-bit level for the PWM stage, plus an illegal-transition diagnostic counter.
module quad_decoder #(
    parameter int FILTER_LEN       = 4,
    parameter int STEPS_PER_DETENT = 4,
    parameter int WIDTH            = 8,
    parameter int SATURATE         = 1
) (
    input logic           clk,
    input logic           reset,
    quad_decoder_if.slave bus
);
    localparam int CNT_W = 4;
    localparam logic signed [3:0] SUB_TOP = 4'(STEPS_PER_DETENT - 1);
    localparam logic signed [3:0] SUB_BOT = -SUB_TOP;
    localparam logic [WIDTH-1:0]  VAL_MAX = '1;

    // Gray position of a {a,b} pair along the up sequence 00-01-11-10.
    function automatic logic [1:0] phase_idx(input logic [1:0] s);
        case (s)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [1:0]            sync1, sync2, filt, prev;
    logic [1:0][CNT_W-1:0] flt_cnt;
    logic signed [3:0]     sub;
    logic [WIDTH-1:0]      value;
    logic                  step, dir, err;
    logic [7:0]            err_count;
    logic [1:0]            delta;
    logic                  mv_up, mv_dn, illegal;

    // NOTE: non-blocking assignments make sync2 take the previous sync1, so the chain really is two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            filt    <= '0;
            flt_cnt <= '0;
        end else begin
            sync1 <= {bus.enc_a, bus.enc_b};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Distance 2 around the gray ring means both phases moved in one filtered update.
    always_comb begin
        delta   = phase_idx(filt) - phase_idx(prev);
        mv_up   = (delta == 2'd1);
        mv_dn   = (delta == 2'd3);
        illegal = (delta == 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev      <= '0;
            sub       <= '0;
            value     <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            prev <= filt;
            step <= 1'b0;
            err  <= 1'b0;
            if (bus.clear) begin
                value     <= '0;
                sub       <= '0;
                err_count <= '0;
            end else if (illegal) begin
                err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 1'b1;
            end else if (mv_up) begin
                if (sub == SUB_TOP) begin
                    sub <= '0;
                    if (!(SATURATE != 0 && value == VAL_MAX)) begin
                        value <= value + 1'b1;
                        step  <= 1'b1;
                        dir   <= 1'b1;
                    end
                end else begin
                    sub <= sub + 4'sd1;
                end
            end else if (mv_dn) begin
                if (sub == SUB_BOT) begin
                    sub <= '0;
                    if (!(SATURATE != 0 && value == '0)) begin
                        value <= value - 1'b1;
                        step  <= 1'b1;
                        dir   <= 1'b0;
                    end
                end else begin
                    sub <= sub - 4'sd1;
                end
            end
        end
    end

    assign bus.value     = value;
    assign bus.step      = step;
    assign bus.dir       = dir;
    assign bus.err       = err;
    assign bus.err_count = err_count;
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Upstream input stage for one rotary-encoder channel of the LED mixer; one instance per encoder.
- Takes raw, asynchronous, bouncy quadrature pins A/B and synchronises and glitch-filters them.
- Decodes full 4x quadrature, divides down to mechanical detents and maintains a WIDTH-bit level register that feeds the per-LED PWM stage.
- Also flags and counts illegal transitions (both phases changing at once) for bring-up diagnostics.

Parameters:
- FILTER_LEN, 4: consecutive stable samples (2..15) required before a filtered phase changes.
- STEPS_PER_DETENT, 4: quadrature transitions per output count; legal values 1, 2, 4.
- WIDTH, 8: width of value output.
- SATURATE, 1: 1 = clamp value at 0 and 2^WIDTH-1; 0 = wrap modulo 2^WIDTH.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: one clock; reset is asynchronous and active-low (0 = reset asserted).
- enc_a, input, 1: raw encoder phase A, asynchronous to clk.
- enc_b, input, 1: raw encoder phase B, asynchronous to clk.
- clear, input, 1: synchronous; zeroes value, sub-count and err_count.
- value, output, WIDTH: current level.
- step, output, 1: one-cycle pulse when value changes.
- dir, output, 1: direction of last value change (1 = up).
- err, output, 1: one-cycle pulse on illegal transition.
- err_count, output, 8: saturating illegal-transition count.

Behaviour:
- Reset (reset=0, async): sync flops, filtered phases, prev-state, filter counters and sub-count = 0; value=0, step=0, dir=0, err=0, err_count=0. Reset mid-operation discards any pending filter count or partial detent.
- Sync: two-flop synchroniser per phase.
- Filter: per phase, a counter increments while the synchronised level differs from the filtered level, and clears whenever they agree. On reaching FILTER_LEN, the filtered level takes the synchronised level and the counter clears. Pulses shorter than FILTER_LEN cycles are ignored.
- Decoder: compares registered prev = {fa,fb} with the current {fa,fb} every cycle; prev then takes the current state.
  - Up sequence: 00→01→11→10→00 gives +1 transition.
  - Exact reverse gives -1.
  - No change: nothing.
  - Both bits changed: err pulses for 1 cycle; err_count +1, saturating at 255; sub-count and value unchanged.
- Detent divider: signed sub-count in range ±STEPS_PER_DETENT.
  - +1 transition at sub = STEPS_PER_DETENT-1: sub←0, value increments.
  - -1 transition at sub = -(STEPS_PER_DETENT-1): sub←0, value decrements.
  - Otherwise sub accumulates; a reversal mid-detent counts back toward 0.
- Value update:
  - SATURATE=1: increment at max or decrement at 0 leaves value unchanged, no step, dir unchanged.
  - SATURATE=0: wraps (max→0, 0→max).
  - Every actual change: step=1 for exactly one cycle, dir set to 1 (up) or 0 (down), registered together with value.
- Latency: a clean level change on a phase that is first sampled at clk edge N appears in the filtered level at edge N+1+FILTER_LEN. value/step/dir/err update at edge N+2+FILTER_LEN, i.e. FILTER_LEN+3 edges counted inclusive of edge N.
- clear:
  - Sets value=0, sub=0, err_count=0 on the next edge.
  - Takes priority over a same-cycle detent or error: no step, no err.
  - Does not disturb sync/filter/prev state.
- Outputs are fully registered; no combinational path from inputs to outputs.

Test Plan:
- Reset check: hold reset=0, toggle inputs → all outputs 0. Release reset, no input activity for 100 cycles → value=0, step never asserted.
- Up detents (defaults): drive one full clean up-cycle 00→01→11→10→00, each state held 20 cycles → step exactly once, value=1, dir=1, at FILTER_LEN+3 edges after the first edge sampling enc_a/enc_b=00. Repeat 3 more cycles → value=4.
- Bounce/glitch: insert 1-3 cycle pulses on enc_a between clean states → no change in value and no err. A 4-cycle-stable pulse is accepted as a real transition.
- Boundaries, SATURATE=1: 5 down detents from 0 → value stays 0, no step. Drive to 255 and apply one more up detent → stays 255. Same stimulus with SATURATE=0 → 255→0 with step=1, dir=1, and 0 down → 255 with dir=0.
- Reversal and illegal transitions: half detent up then back down → value unchanged, no step. Force 00→11 in one filtered update → err pulse one cycle, err_count=1, value unchanged. 300 illegal transitions → err_count=255.
- Clear collision: assert clear on the same cycle a detent completes with value=7 → value=0, step=0, err_count=0 next cycle. The following full up detent gives value=1.
